ring_fifo: RTL and testbench
============================

RING_FIFO -- requirements
Module: ring_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits, at least 1.
REQ-002 SHALL have parameter DEPTH, default 8: number of storage entries, at least 2; need not be a power of two.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full threshold, with 1 <= AF_LEVEL <= DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty threshold, with 0 <= AE_LEVEL < DEPTH.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port flush, input, 1 bit: synchronous empty request.
REQ-008 SHALL have port in_data, input, WIDTH bits: write data.
REQ-009 SHALL have port in_valid, input, 1 bit: write request.
REQ-010 SHALL have port in_ready, output, 1 bit: space available.
REQ-011 SHALL have port out_data, output, WIDTH bits: head-of-queue data.
REQ-012 SHALL have port out_valid, output, 1 bit: head-of-queue data valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the head word.
REQ-014 SHALL have port count, output, CW bits: occupancy, where CW = $clog2(DEPTH+1) so that DEPTH itself is representable.
REQ-015 SHALL have ports almost_full and almost_empty, outputs, 1 bit each: registered threshold flags.

Function
REQ-016 SHALL accept a push when in_valid && in_ready, and a pop when out_valid && out_ready.
REQ-017 SHALL drive in_ready = (count != DEPTH) and out_valid = (count != 0), both decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-018 SHALL be first-word-fall-through: out_data = mem[rd_ptr]; a word pushed into an empty FIFO at edge N appears with out_valid=1 after edge N (one-cycle latency).
REQ-019 SHALL keep out_data stable while out_valid && !out_ready.
REQ-020 SHALL hold out_data at a don't-care value while out_valid=0; the bench shall not check it.
REQ-021 SHALL store a push at mem[wr_ptr] and advance wr_ptr; a pop SHALL advance rd_ptr.
REQ-022 SHALL wrap each pointer from DEPTH-1 to 0 and never let it reach DEPTH.
REQ-023 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 When full, in_ready=0 even if out_ready=1; only the pop is taken that cycle.
REQ-025 When empty, a push SHALL take count 0->1; no pop occurs that cycle.
REQ-026 SHALL change count by exactly +1 (push only), -1 (pop only) or 0; it SHALL never leave the range 0..DEPTH.
REQ-027 SHALL register almost_full = (next count >= AF_LEVEL) and almost_empty = (next count <= AE_LEVEL), so both flags update on the same edge as count.
REQ-028 SHALL give flush priority over everything else: at the next edge, pointers=0, count=0, almost_full=0 and almost_empty=1.
REQ-029 SHALL discard any push or pop presented in the same cycle as flush.
REQ-030 SHALL leave memory contents unmodified by flush.

Reset
REQ-031 SHALL, on assertion of rst and independent of clk, immediately force wr_ptr=0, rd_ptr=0, count=0, almost_full=0 and almost_empty=1.
REQ-032 During reset, in_ready=0 and out_valid=0.
REQ-033 After deassertion, in_ready=1 from the first clock edge.
REQ-034 SHALL not reset the memory array; memory is clk-only flops or RAM.
REQ-035 SHALL abandon any transfer in progress when rst asserts mid-operation; no push or pop from that cycle is retained.

Structure
REQ-036 SHALL place the function fifo_cnt_w(depth), returning $clog2(depth+1), in shared package fifo_pkg, for use by all FIFO users.
REQ-037 SHALL implement the two pointers as instances of a sub-module ring_ptr (parameter DEPTH; ports clk, rst, clr, inc, ptr), a wrapping mod-DEPTH counter.
REQ-038 Storage SHALL be a single unpacked array of DEPTH x WIDTH with one write port and one combinational read port.

Verification
REQ-039 Fill/drain (WIDTH=8, DEPTH=5): push 0x11..0x15 with out_ready=0 -> count 1..5, in_ready=0 after the fifth push, almost_full=1 at count 4; then drain -> words popped in order 0x11..0x15, almost_empty=1 at count 1.
REQ-040 Wrap: 3 pushes, 3 pops, then 4 pushes of 0xA0..0xA3 and 4 pops -> data in order; wr_ptr passes 4->0 with no loss.
REQ-041 Full simultaneous: at count 5, assert in_valid=1 and out_ready=1 -> pop only, count=4, in_data dropped; next cycle the push is accepted and count returns to 5.
REQ-042 Steady stream: continuous in_valid and out_ready for 20 cycles starting from count 2 -> count stays at 2 and the output sequence equals the input sequence delayed by 2 words.
REQ-043 Flush: at count 3, assert flush with in_valid=1 -> next edge count=0, out_valid=0, almost_empty=1; the next push of 0x5A is the first word out.
REQ-044 Async reset: assert rst between edges at count 4 -> count=0, out_valid=0 and almost_full=0 before the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for FIFO users
package fifo_pkg;
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ring_fifo_ptr.sv
// ring_ptr: wrapping mod-DEPTH pointer with synchronous clear
module ring_ptr #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [PW-1:0] ptr_q, ptr_d;
  // next pointer: clear wins, otherwise step and wrap at the last entry
  always_comb ptr_d = clr ? '0 : inc ? (ptr_q == LAST ? '0 : ptr_q + PW'(1)) : ptr_q;
  // pointer register
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/ring_fifo.sv
// ring_fifo: first-word-fall-through ring buffer FIFO with registered threshold flags
module ring_fifo import fifo_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW = fifo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE = CW'(AE_LEVEL);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic af_q, ae_q, rdy_q;
  logic push, pop;
  assign in_ready = rdy_q && cnt_q != FULL;
  assign out_valid = cnt_q != '0;
  assign out_data = mem[rd_ptr];
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready && !flush;
  assign count = cnt_q;
  assign almost_full = af_q;
  assign almost_empty = ae_q;
  ring_ptr #(.DEPTH(DEPTH)) u_wr (.clk(clk), .rst(rst), .clr(flush), .inc(push), .ptr(wr_ptr));
  ring_ptr #(.DEPTH(DEPTH)) u_rd (.clk(clk), .rst(rst), .clr(flush), .inc(pop), .ptr(rd_ptr));
  // next occupancy: flush empties, lone push/pop steps by one, both or neither holds
  always_comb cnt_d = flush ? '0 : (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
  // occupancy and flags share one edge; rdy_q keeps in_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      af_q <= 1'b0;
      ae_q <= 1'b1;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      af_q <= cnt_d >= AF;
      ae_q <= cnt_d <= AE;
      rdy_q <= 1'b1;
    end
  // storage write port; contents survive reset and flush
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
endmodule

// File: tb/tb_ring_fifo.sv
// tb_ring_fifo: randomized scoreboard bench for ring_fifo (WIDTH=8, DEPTH=5)
module tb_ring_fifo;
  localparam int DEPTH = 5;
  localparam int AF_LEVEL = 4;
  localparam int AE_LEVEL = 1;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0, out_data;
  logic in_ready, out_valid, almost_full, almost_empty;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mq [$];
  logic [7:0] sb [$];

  ring_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state();
    int n = mq.size();
    chk("count", int'(count), n);
    chk("in_ready", int'(in_ready), int'(n != DEPTH));
    chk("out_valid", int'(out_valid), int'(n != 0));
    chk("almost_full", int'(almost_full), int'(n >= AF_LEVEL));
    chk("almost_empty", int'(almost_empty), int'(n <= AE_LEVEL));
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
    bit do_push, do_pop;
    @(negedge clk);
    chk_state();
    #2;
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    do_push = v && mq.size() != DEPTH && !f;
    do_pop = r && mq.size() != 0 && !f;
    if (f) begin
      mq.delete();
      sb.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(d);
        sb.push_back(d);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    #1;
    mq.delete();
    sb.delete();
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_almost_empty", int'(almost_empty), 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("pre_edge_in_ready", int'(in_ready), 0);
  endtask

  initial forever begin
    @(negedge clk);
    #3;
    if (!rst && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got data %0h expected no word", out_data);
      end else chk("out_data", int'(out_data), int'(sb.pop_front()));
    end
  end

  initial begin
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h11 + i), 0, 0);
    cyc(1, 8'hFF, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
    cyc(1, 8'hEE, 1, 0);
    cyc(1, 8'hEF, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0);
    cyc(1, 8'h20, 0, 0);
    cyc(1, 8'h21, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'h30 + i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h60 + i), 0, 0);
    cyc(1, 8'h77, 1, 1);
    cyc(1, 8'h5A, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h90 + i), 0, 0);
    cyc(0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) != 0, $urandom_range(0, 31) == 0);
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk_state();
    #4;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
